// File: rtl/present_enc_primitives.sv
// PRESENT-80 building blocks: a registered S-layer/P-layer datapath and a
// 31-update key-schedule engine that leaves the round-32 key register on key_out.
module present_enc_primitives (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dp_valid,
  input  logic [63:0] data_in,
  input  logic        start,
  input  logic [79:0] key_in,
  output logic [63:0] sbox_out,
  output logic [63:0] pbox_out,
  output logic        dp_valid_out,
  output logic        busy,
  output logic [79:0] key_out,
  output logic        key_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  logic [63:0] w_sbox_layer;
  logic [63:0] w_pbox_layer;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      assign w_sbox_layer[4*gi+3:4*gi] = sbox4(data_in[4*gi+3:4*gi]);
    end
    // Bit i lands on 16*i mod 63; the MSB is a fixed point of the permutation.
    for (gi = 0; gi < 63; gi++) begin : g_pbox
      assign w_pbox_layer[(16*gi) % 63] = data_in[gi];
    end
  endgenerate
  assign w_pbox_layer[63] = data_in[63];

  logic [63:0] r_sbox;
  logic [63:0] r_pbox;
  logic        r_dp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sbox     <= 64'd0;
      r_pbox     <= 64'd0;
      r_dp_valid <= 1'b0;
    end else begin
      r_dp_valid <= dp_valid;
      if (dp_valid) begin
        r_sbox <= w_sbox_layer;
        r_pbox <= w_pbox_layer;
      end
    end
  end

  state_t      r_state;
  state_t      w_state_next;
  logic [79:0] r_key;
  logic [79:0] w_key_next;
  logic [4:0]  r_rc;
  logic [4:0]  w_rc_next;
  logic        r_key_done;
  logic        w_key_done_next;

  logic [79:0] w_key_rot;
  logic [79:0] w_key_upd;

  assign w_key_rot = {r_key[18:0], r_key[79:19]};
  assign w_key_upd = {sbox4(w_key_rot[79:76]), w_key_rot[75:20],
                      w_key_rot[19:15] ^ r_rc, w_key_rot[14:0]};

  always_comb begin
    w_state_next    = r_state;
    w_key_next      = r_key;
    w_rc_next       = r_rc;
    w_key_done_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_key_next   = key_in;
          w_rc_next    = 5'd1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_key_next = w_key_upd;
        w_rc_next  = r_rc + 5'd1;
        // rc=31 is the last of the 31 updates.
        if (r_rc == 5'd31) begin
          w_state_next    = ST_IDLE;
          w_key_done_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_key      <= 80'd0;
      r_rc       <= 5'd0;
      r_key_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_key      <= w_key_next;
      r_rc       <= w_rc_next;
      r_key_done <= w_key_done_next;
    end
  end

  assign sbox_out     = r_sbox;
  assign pbox_out     = r_pbox;
  assign dp_valid_out = r_dp_valid;
  assign busy         = (r_state == ST_RUN);
  assign key_out      = r_key;
  assign key_done     = r_key_done;

endmodule

// File: tb/tb_present_enc_primitives.sv
// Directed bench for present_enc_primitives: datapath vectors, key-schedule runs,
// ignored restarts, mid-run reset and concurrent datapath traffic.
module tb_present_enc_primitives;

  logic        clk;
  logic        rst_n;
  logic        dp_valid;
  logic [63:0] data_in;
  logic        start;
  logic [79:0] key_in;
  logic [63:0] sbox_out;
  logic [63:0] pbox_out;
  logic        dp_valid_out;
  logic        busy;
  logic [79:0] key_out;
  logic        key_done;

  int n_checks = 0;
  int n_errors = 0;

  present_enc_primitives dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dp_valid     (dp_valid),
    .data_in      (data_in),
    .start        (start),
    .key_in       (key_in),
    .sbox_out     (sbox_out),
    .pbox_out     (pbox_out),
    .dp_valid_out (dp_valid_out),
    .busy         (busy),
    .key_out      (key_out),
    .key_done     (key_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_sbox(input logic [3:0] v);
    logic [63:0] tbl;
    int          idx;
    tbl = 64'hC56B90AD3EF84712;
    idx = 60 - 4 * int'(v);
    return tbl[idx +: 4];
  endfunction

  function automatic logic [63:0] m_slayer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = m_sbox(x[4*i +: 4]);
    return r;
  endfunction

  // Inverse view of the permutation: output j takes input 4*j mod 63.
  function automatic logic [63:0] m_player(input logic [63:0] x);
    logic [63:0] r;
    for (int j = 0; j < 63; j++) r[j] = x[(4*j) % 63];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [79:0] m_k32(input logic [79:0] k0);
    logic [79:0] k;
    logic [79:0] t;
    logic [4:0]  rc;
    k = k0;
    for (int r = 1; r <= 31; r++) begin
      for (int j = 0; j < 80; j++) t[(j + 61) % 80] = k[j];
      t[79:76] = m_sbox(t[79:76]);
      rc = 5'(r);
      t[19:15] = t[19:15] ^ rc;
      k = t;
    end
    return k;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("%s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " sbox_out"}, 80'(sbox_out), 80'd0);
    chk({tag, " pbox_out"}, 80'(pbox_out), 80'd0);
    chk({tag, " dp_valid_out"}, 80'(dp_valid_out), 80'd0);
    chk({tag, " busy"}, 80'(busy), 80'd0);
    chk({tag, " key_out"}, key_out, 80'd0);
    chk({tag, " key_done"}, 80'(key_done), 80'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [79:0] k_a;
    logic [79:0] k_b;
    logic [79:0] k_c;
    logic [79:0] k32_zero;
    int          done_seen;
    k_a = 80'h0123_4567_89AB_CDEF_FEDC;
    k_b = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    k_c = 80'hA5A5_3C3C_0F0F_1234_9876;

    // Reset with start and dp_valid asserted: reset must win.
    rst_n = 1'b0; dp_valid = 1'b1; start = 1'b1;
    data_in = 64'h0123456789ABCDEF; key_in = k_a;
    step(); step();
    chk_all_zero("reset");
    $display("step reset: outputs cleared");
    rst_n = 1'b1; dp_valid = 1'b0; start = 1'b0;
    step();
    chk("idle busy", 80'(busy), 80'd0);

    // S-layer reference vector.
    dp_valid = 1'b1; data_in = 64'h0123456789ABCDEF;
    step();
    chk("sbox ref", 80'(sbox_out), 80'h0000_C56B90AD3EF84712);
    chk("sbox ref pbox", 80'(pbox_out), 80'(m_player(64'h0123456789ABCDEF)));
    chk("sbox ref dv", 80'(dp_valid_out), 80'd1);
    $display("step sbox ref: sbox_out=%h", sbox_out);
    dp_valid = 1'b0; data_in = 64'hFFFF_0000_FFFF_0000;
    step();
    chk("hold dv", 80'(dp_valid_out), 80'd0);
    chk("hold sbox", 80'(sbox_out), 80'h0000_C56B90AD3EF84712);

    // P-layer vectors on consecutive cycles.
    dp_valid = 1'b1; data_in = 64'h0000000000000002;
    step();
    chk("pbox bit1", 80'(pbox_out), 80'h0000_0000000000010000);
    data_in = 64'h4000000000000000;
    step();
    chk("pbox bit62", 80'(pbox_out), 80'h0000_0000800000000000);
    data_in = 64'h8000000000000001;
    step();
    chk("pbox fixed", 80'(pbox_out), 80'h0000_8000000000000001);
    chk("pbox fixed dv", 80'(dp_valid_out), 80'd1);
    $display("step pbox vectors: last pbox_out=%h", pbox_out);
    dp_valid = 1'b0;

    // Key run with key_in = 0.
    k32_zero = m_k32(80'd0);
    start = 1'b1; key_in = 80'd0;
    step();
    start = 1'b0;
    chk("run0 E0 busy", 80'(busy), 80'd1);
    chk("run0 E0 key", key_out, 80'd0);
    step();
    chk("run0 E1 key", key_out, 80'hC000_0000_0000_0000_8000);
    done_seen = 0;
    for (int e = 2; e <= 30; e++) begin
      step();
      if (key_done) done_seen++;
    end
    chk("run0 early done", 80'(done_seen), 80'd0);
    step();
    chk("run0 E31 done", 80'(key_done), 80'd1);
    chk("run0 E31 busy", 80'(busy), 80'd0);
    chk("run0 K32", key_out, k32_zero);
    $display("step run0: key_out=%h", key_out);
    step();
    chk("run0 done pulse", 80'(key_done), 80'd0);
    chk("run0 key hold", key_out, k32_zero);

    // Restarts at E5 and E20 are ignored.
    start = 1'b1; key_in = k_a;
    step();
    done_seen = 0;
    for (int e = 1; e <= 31; e++) begin
      start = (e == 5 || e == 20);
      key_in = ~k_a;
      step();
      if (e < 31 && key_done) done_seen++;
    end
    start = 1'b0;
    chk("restart early done", 80'(done_seen), 80'd0);
    chk("restart E31 done", 80'(key_done), 80'd1);
    chk("restart K32", key_out, m_k32(k_a));
    $display("step restart-ignored: key_out=%h", key_out);

    // Start in the key_done cycle is accepted.
    start = 1'b1; key_in = k_b;
    step();
    start = 1'b0;
    chk("done-cycle start done", 80'(key_done), 80'd0);
    chk("done-cycle start busy", 80'(busy), 80'd1);
    chk("done-cycle start key", key_out, k_b);

    // Reset at E10 of that run.
    for (int e = 1; e <= 9; e++) step();
    rst_n = 1'b0;
    step();
    chk_all_zero("midrun reset");
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (key_done || busy) done_seen++;
    end
    chk("post reset quiet", 80'(done_seen), 80'd0);
    $display("step midrun reset: aborted");

    // Fresh run with datapath traffic every cycle.
    done_seen = 0;
    for (int e = 0; e <= 31; e++) begin
      start = (e == 0);
      key_in = k_c;
      dp_valid = 1'b1;
      d = {$urandom, $urandom};
      data_in = d;
      step();
      chk("traffic sbox", 80'(sbox_out), 80'(m_slayer(d)));
      chk("traffic pbox", 80'(pbox_out), 80'(m_player(d)));
      chk("traffic dv", 80'(dp_valid_out), 80'd1);
      if (e < 31 && key_done) done_seen++;
    end
    start = 1'b0; dp_valid = 1'b0;
    chk("traffic early done", 80'(done_seen), 80'd0);
    chk("traffic E31 done", 80'(key_done), 80'd1);
    chk("traffic K32", key_out, m_k32(k_c));
    $display("step traffic run: key_out=%h", key_out);
    step();
    chk("traffic dv low", 80'(dp_valid_out), 80'd0);
    chk("traffic done pulse", 80'(key_done), 80'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/present_enc_primitives.md
PRESENT_ENC_PRIMITIVES -- requirements
Module: present_enc_primitives

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as below.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 dp_valid  input  1  sample data_in into the S-layer and P-layer output registers this cycle.
REQ-005 data_in  input  64  datapath operand.
REQ-006 start  input  1  begin key-schedule run on key_in; honoured only when busy=0.
REQ-007 key_in  input  80  user key, sampled only when start is accepted.
REQ-008 sbox_out  output  64  registered S-layer of the last sampled data_in.
REQ-009 pbox_out  output  64  registered P-layer of the last sampled data_in.
REQ-010 dp_valid_out  output  1  high the cycle after a dp_valid sample, else low.
REQ-011 busy  output  1  key schedule running.
REQ-012 key_out  output  80  current key register, always visible.
REQ-013 key_done  output  1  one-cycle pulse; key_out holds the round-32 key register.

Function
REQ-014 S-box: 4-bit map 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-015 S-layer: 16 parallel S-boxes on nibbles [4i+3:4i], i=0..15.
REQ-016 P-layer: input bit i -> output bit (16*i mod 63) for i=0..62; bit 63 -> bit 63.
REQ-017 On a dp_valid edge, sbox_out <= S-layer(data_in) and pbox_out <= P-layer(data_in), both from the same data_in; latency 1 cycle.
REQ-018 Without dp_valid, sbox_out and pbox_out hold; dp_valid_out goes low.
REQ-019 The datapath operates independently of the key schedule; dp_valid is accepted while busy=1.
REQ-020 Key register K is 80 bits with round counter rc of 5 bits.
REQ-021 Accepted start (start=1, busy=0): K <= key_in, rc <= 1, busy <= 1.
REQ-022 Each busy cycle performs one update:
- K <= rotate-left-61(K)
- then K[79:76] <= S(K[79:76])
- then K[19:15] <= K[19:15] xor rc
- rc <= rc+1
REQ-023 Exactly 31 updates SHALL occur (rc=1..31); the edge applying rc=31 sets key_done=1 and busy=0.
REQ-024 Timing: start sampled at edge E0 -> updates at edges E1..E31 -> key_done high during the cycle after E31.
REQ-025 key_out after E31 = round-32 key register; key_out[79:16] = last round key. key_out holds until the next accepted start or reset.
REQ-026 start while busy=1 is ignored; no restart, key_in not sampled.
REQ-027 start in the key_done cycle is accepted, since busy=0 then; key_done still deasserts next cycle.
REQ-028 key_done is never high for more than one consecutive cycle.

Reset
REQ-029 rst_n=0 at an edge clears to zero: sbox_out, pbox_out, dp_valid_out, key_out, rc, busy, key_done.
REQ-030 Reset overrides start and dp_valid in the same cycle.
REQ-031 Reset mid-run aborts the run with no key_done; the next accepted start restarts from key_in.

Verification
REQ-032 dp_valid, data_in=0123456789ABCDEF -> next cycle sbox_out=C56B90AD3EF84712, dp_valid_out=1.
REQ-033 P-layer vectors, next cycle after dp_valid:
- data_in=0000000000000002 -> pbox_out=0000000000010000
- data_in=4000000000000000 -> pbox_out=0000800000000000
- data_in=8000000000000001 -> pbox_out=8000000000000001
REQ-034 start, key_in=0 -> after E1 key_out=C0000000000000008000; key_done exactly one cycle after E31; key_out matches software PRESENT-80 model K32.
REQ-035 start pulsed again at E5 and E20 of a run -> ignored; single key_done at E31, result unchanged.
REQ-036 rst_n=0 at E10 of a run -> all outputs 0, no key_done; fresh start completes normally 31 edges later.
REQ-037 dp_valid every cycle during a key run, random data -> sbox/pbox outputs match model each cycle; key result unaffected.
